// File: rtl/pscb_route_pipe.sv
// Registered butterfly routing pipeline steered by per-stage swap/pass controls.
// Stage STAGES-1 works on the input beat; stage 0's register drives the outputs.
module pscb_route_pipe #(
  parameter int INPUTS = 128,
  parameter int DATA_W = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_cfg_valid,
  output logic                                o_cfg_ready,
  input  logic [INPUTS/2*$clog2(INPUTS)-1:0]  i_scb,
  input  logic [INPUTS/2*$clog2(INPUTS)-1:0]  i_pass,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [INPUTS*DATA_W-1:0]            i_data,
  input  logic [INPUTS-1:0]                   i_lane_vld,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [INPUTS*DATA_W-1:0]            o_data,
  output logic [INPUTS-1:0]                   o_lane_vld,
  output logic                                o_busy
);
  localparam int NODES  = INPUTS / 2;
  localparam int STAGES = $clog2(INPUTS);
  localparam int CW     = NODES * STAGES;
  localparam int DW     = INPUTS * DATA_W;

  // Handshakes: a beat transfers on any edge where valid and ready are both
  // high; valid never waits on ready, and held content stays stable until taken.

  logic [CW-1:0]     r_scb;
  logic [CW-1:0]     r_pass;
  logic [STAGES-1:0] r_v;
  logic [DW-1:0]     r_data [STAGES];
  logic [INPUTS-1:0] r_lv   [STAGES];

  logic [DW-1:0]     w_src_d [STAGES];
  logic [INPUTS-1:0] w_src_l [STAGES];
  logic [DW-1:0]     w_dout  [STAGES];
  logic [INPUTS-1:0] w_lout  [STAGES];
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_up_v;
  logic              w_in_fire;
  logic              w_cfg_fire;

  function automatic int lane_a(input int s, input int n);
    return ((n >> s) << (s + 1)) | (n & ((1 << s) - 1));
  endfunction

  function automatic int lane_b(input int s, input int n);
    return lane_a(s, n) + (1 << s);
  endfunction

  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == STAGES - 1) begin : g_top
      assign w_src_d[g] = i_data;
      assign w_src_l[g] = i_lane_vld;
    end else begin : g_mid
      assign w_src_d[g] = r_data[g + 1];
      assign w_src_l[g] = r_lv[g + 1];
    end
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_dout[s] = w_src_d[s];
      w_lout[s] = w_src_l[s];
      for (int n = 0; n < NODES; n++) begin
        if (r_scb[s*NODES + n]) begin
          w_dout[s][lane_a(s, n)*DATA_W +: DATA_W] = w_src_d[s][lane_b(s, n)*DATA_W +: DATA_W];
          w_dout[s][lane_b(s, n)*DATA_W +: DATA_W] = w_src_d[s][lane_a(s, n)*DATA_W +: DATA_W];
        end
        // Flags follow the swap, then a cleared pass bit kills both of them.
        w_lout[s][lane_a(s, n)] = r_pass[s*NODES + n] &
          (r_scb[s*NODES + n] ? w_src_l[s][lane_b(s, n)] : w_src_l[s][lane_a(s, n)]);
        w_lout[s][lane_b(s, n)] = r_pass[s*NODES + n] &
          (r_scb[s*NODES + n] ? w_src_l[s][lane_a(s, n)] : w_src_l[s][lane_b(s, n)]);
      end
    end
  end

  // Stage k can load when it or any stage below it is empty, or the output drains.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_load[k] = i_ready;
      for (int j = 0; j <= k; j++) begin
        if (!r_v[j]) w_load[k] = 1'b1;
      end
    end
  end

  assign o_busy      = |r_v;
  assign o_cfg_ready = ~o_busy & ~i_valid;
  assign w_cfg_fire  = i_cfg_valid & o_cfg_ready;
  assign o_ready     = w_load[STAGES-1] & ~w_cfg_fire;
  assign w_in_fire   = i_valid & o_ready;
  assign w_up_v      = STAGES'({w_in_fire, r_v} >> 1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v    <= '0;
      r_scb  <= '0;
      r_pass <= '1;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) r_v[k] <= w_up_v[k];
      end
      if (w_cfg_fire) begin
        r_scb  <= i_scb;
        r_pass <= i_pass;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (w_load[k]) begin
        r_data[k] <= w_dout[k];
        r_lv[k]   <= w_lout[k];
      end
    end
  end

  assign o_valid    = r_v[0];
  assign o_data     = r_data[0];
  assign o_lane_vld = r_lv[0] & {INPUTS{r_v[0]}};

endmodule

// File: tb/tb_pscb_route_pipe.sv
// Randomised bench for pscb_route_pipe with a lane-centric routing model and
// an expected-beat queue fed and drained by a negedge monitor.
module tb_pscb_route_pipe;
  localparam int INPUTS = 8;
  localparam int DATA_W = 8;
  localparam int NODES  = INPUTS / 2;
  localparam int STAGES = 3;
  localparam int CW     = NODES * STAGES;
  localparam int DW     = INPUTS * DATA_W;
  localparam int W      = DW + INPUTS;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_cfg_valid = 1'b0;
  logic              o_cfg_ready;
  logic [CW-1:0]     i_scb = '0;
  logic [CW-1:0]     i_pass = '1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [DW-1:0]     i_data = '0;
  logic [INPUTS-1:0] i_lane_vld = '0;
  logic              o_valid;
  logic              i_ready = 1'b1;
  logic [DW-1:0]     o_data;
  logic [INPUTS-1:0] o_lane_vld;
  logic              o_busy;

  logic [W-1:0]      exp_q[$];
  logic [CW-1:0]     m_scb = '0;
  logic [CW-1:0]     m_pass = '1;
  logic              hold_pend = 1'b0;
  logic [DW-1:0]     hold_d;
  logic [INPUTS-1:0] hold_l;
  int                n_cmp = 0;
  int                n_err = 0;

  pscb_route_pipe #(.INPUTS(INPUTS), .DATA_W(DATA_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_scb(i_scb), .i_pass(i_pass),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_lane_vld(i_lane_vld),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_lane_vld(o_lane_vld), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Lane view: at stage s lane l meets lane l^2^s; its node index is l with bit s removed.
  function automatic logic [W-1:0] ref_route(input logic [DW-1:0] d_in, input logic [INPUTS-1:0] f_in,
                                             input logic [CW-1:0] scb, input logic [CW-1:0] pass);
    logic [DATA_W-1:0] d [INPUTS];
    logic [DATA_W-1:0] nd [INPUTS];
    logic              f [INPUTS];
    logic              nf [INPUTS];
    logic [W-1:0]      r;
    int                p, n;
    logic              sw, ps;
    for (int l = 0; l < INPUTS; l++) begin
      d[l] = d_in[l*DATA_W +: DATA_W];
      f[l] = f_in[l];
    end
    for (int s = STAGES - 1; s >= 0; s--) begin
      for (int l = 0; l < INPUTS; l++) begin
        p = l ^ (1 << s);
        n = ((l >> (s + 1)) << s) | (l & ((1 << s) - 1));
        sw = scb[s*NODES + n];
        ps = pass[s*NODES + n];
        nd[l] = sw ? d[p] : d[l];
        nf[l] = ps & (sw ? f[p] : f[l]);
      end
      d = nd;
      f = nf;
    end
    for (int l = 0; l < INPUTS; l++) begin
      r[l*DATA_W +: DATA_W] = d[l];
      r[DW + l] = f[l];
    end
    return r;
  endfunction

  // Scoreboard monitor: observes every transfer mid-cycle, ahead of the edge that performs it.
  always @(negedge i_clk) begin
    logic [W-1:0] e;
    if (!i_rst_n) begin
      exp_q.delete();
      m_scb = '0;
      m_pass = '1;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        n_cmp++;
        if (o_valid !== 1'b1 || o_data !== hold_d || o_lane_vld !== hold_l) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b data=%h lv=%h, required v=1 data=%h lv=%h",
                   o_valid, o_data, o_lane_vld, hold_d, hold_l);
        end
      end
      if (o_valid && i_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got data=%h lv=%h, required no beat", o_data, o_lane_vld);
        end else begin
          e = exp_q.pop_front();
          if ({o_lane_vld, o_data} !== e) begin
            n_err++;
            $display("FAIL out_beat: got lv=%h data=%h, required lv=%h data=%h",
                     o_lane_vld, o_data, e[DW +: INPUTS], e[DW-1:0]);
          end
        end
      end
      hold_pend = o_valid && !i_ready;
      hold_d = o_data;
      hold_l = o_lane_vld;
      if (i_valid && o_ready) exp_q.push_back(ref_route(i_data, i_lane_vld, m_scb, m_pass));
      if (i_cfg_valid && o_cfg_ready) begin
        m_scb = i_scb;
        m_pass = i_pass;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_cfg_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  task automatic rand_beat();
    i_data = {$urandom, $urandom};
    i_lane_vld = INPUTS'($urandom);
  endtask

  task automatic drain();
    int c = 0;
    idle();
    while ((exp_q.size() != 0 || o_busy) && c < 40) begin
      tick();
      c++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain: got pending=%0d busy=%b, required pending=0 busy=0", exp_q.size(), o_busy);
    end
  endtask

  // Holds a config offer until it is taken; o_cfg_ready must track an empty pipe.
  task automatic offer_cfg(input logic [CW-1:0] scb, input logic [CW-1:0] pass, output int blocked);
    logic taken = 1'b0;
    blocked = 0;
    i_cfg_valid = 1'b1;
    i_scb = scb;
    i_pass = pass;
    for (int c = 0; c < 30 && !taken; c++) begin
      #1;
      n_cmp++;
      if (o_cfg_ready !== (exp_q.size() == 0 && !i_valid)) begin
        n_err++;
        $display("FAIL cfg_ready: got %b, required %b", o_cfg_ready, (exp_q.size() == 0 && !i_valid));
      end
      if (o_cfg_ready) taken = 1'b1;
      else blocked++;
      tick();
    end
    i_cfg_valid = 1'b0;
    n_cmp++;
    if (!taken) begin
      n_err++;
      $display("FAIL cfg_timeout: got not accepted, required accepted");
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    idle();
    tick();
    tick();
    i_rst_n = 1'b1;
    #1;
    n_cmp += 5;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", o_valid); end
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
    if (o_lane_vld !== '0) begin n_err++; $display("FAIL rst_lane_vld: got %h, required 00", o_lane_vld); end
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b, required 1", o_ready); end
    if (o_cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_cfg_ready: got %b, required 1", o_cfg_ready); end
    tick();
  endtask

  task automatic test_identity();
    logic [DW-1:0] d;
    for (int l = 0; l < INPUTS; l++) d[l*DATA_W +: DATA_W] = 8'h10 + 8'(l);
    i_data = d;
    i_lane_vld = 8'hFF;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int c = 0; c < STAGES - 1; c++) begin
      n_cmp++;
      if (o_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got v=%b at +%0d, required 0", o_valid, c); end
      tick();
    end
    n_cmp += 3;
    if (o_valid !== 1'b1) begin n_err++; $display("FAIL latency: got v=%b, required 1", o_valid); end
    if (o_data !== d) begin n_err++; $display("FAIL ident_data: got %h, required %h", o_data, d); end
    if (o_lane_vld !== 8'hFF) begin n_err++; $display("FAIL ident_lv: got %h, required ff", o_lane_vld); end
    drain();
  endtask

  task automatic test_swap_mask();
    logic [DW-1:0] d;
    logic [W-1:0]  e;
    int            blk;
    offer_cfg(12'h001, ~(12'h1 << (2*NODES + 1)), blk);
    for (int l = 0; l < INPUTS; l++) d[l*DATA_W +: DATA_W] = 8'h10 + 8'(l);
    e = ref_route(d, 8'hFF, 12'h001, ~(12'h1 << (2*NODES + 1)));
    i_data = d;
    i_lane_vld = 8'hFF;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    n_cmp += 4;
    if (o_data[7:0] !== 8'h11) begin n_err++; $display("FAIL swap_lane0: got %h, required 11", o_data[7:0]); end
    if (o_data[15:8] !== 8'h10) begin n_err++; $display("FAIL swap_lane1: got %h, required 10", o_data[15:8]); end
    if (o_lane_vld[5] !== 1'b0) begin n_err++; $display("FAIL mask_lane5: got %b, required 0", o_lane_vld[5]); end
    if (o_lane_vld !== e[DW +: INPUTS]) begin
      n_err++;
      $display("FAIL mask_lv: got %h, required %h", o_lane_vld, e[DW +: INPUTS]);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int  sent = 0;
    logic er;
    for (int c = 0; c < 14; c++) begin
      i_ready = !(c >= 2 && c <= 6);
      i_valid = sent < 6;
      rand_beat();
      #1;
      er = !(exp_q.size() == STAGES && !i_ready);
      n_cmp++;
      if (o_ready !== er) begin n_err++; $display("FAIL bp_ready c=%0d: got %b, required %b", c, o_ready, er); end
      if (i_valid && o_ready) sent++;
      tick();
    end
    n_cmp++;
    if (sent != 6) begin n_err++; $display("FAIL bp_sent: got %0d, required 6", sent); end
    drain();
  endtask

  task automatic test_cfg_blocking();
    int blk;
    for (int c = 0; c < 2; c++) begin
      i_valid = 1'b1;
      rand_beat();
      tick();
    end
    i_valid = 1'b0;
    offer_cfg(CW'($urandom), CW'($urandom), blk);
    n_cmp++;
    if (blk == 0) begin n_err++; $display("FAIL cfg_block: got 0 blocked cycles, required >0"); end
    i_valid = 1'b1;
    rand_beat();
    tick();
    drain();
  endtask

  task automatic test_simul();
    int blk;
    i_valid = 1'b1;
    rand_beat();
    i_cfg_valid = 1'b1;
    i_scb = CW'($urandom);
    i_pass = CW'($urandom);
    #1;
    n_cmp += 2;
    if (o_ready !== 1'b1) begin n_err++; $display("FAIL simul_ready: got %b, required 1", o_ready); end
    if (o_cfg_ready !== 1'b0) begin n_err++; $display("FAIL simul_cfg_ready: got %b, required 0", o_cfg_ready); end
    tick();
    i_valid = 1'b0;
    offer_cfg(i_scb, i_pass, blk);
    i_valid = 1'b1;
    rand_beat();
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0]     d;
    logic [INPUTS-1:0] f;
    for (int c = 0; c < 3; c++) begin
      i_valid = 1'b1;
      rand_beat();
      tick();
    end
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    #1;
    n_cmp += 3;
    if (o_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b, required 0", o_valid); end
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b, required 0", o_busy); end
    if (o_lane_vld !== '0) begin n_err++; $display("FAIL rmid_lv: got %h, required 00", o_lane_vld); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (o_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale c=%0d: got v=%b, required 0", c, o_valid); end
    end
    rand_beat();
    d = i_data;
    f = i_lane_vld;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    n_cmp += 2;
    if (o_data !== d) begin n_err++; $display("FAIL rmid_ident_data: got %h, required %h", o_data, d); end
    if (o_lane_vld !== f) begin n_err++; $display("FAIL rmid_ident_lv: got %h, required %h", o_lane_vld, f); end
    drain();
  endtask

  task automatic test_random();
    logic er, ec;
    for (int c = 0; c < 80; c++) begin
      i_valid = $urandom_range(0, 2) != 0;
      i_ready = $urandom_range(0, 3) != 0;
      i_cfg_valid = $urandom_range(0, 5) == 0;
      i_scb = CW'($urandom);
      i_pass = CW'($urandom);
      rand_beat();
      #1;
      ec = exp_q.size() == 0 && !i_valid;
      er = !(exp_q.size() == STAGES && !i_ready) && !(i_cfg_valid && ec);
      n_cmp += 2;
      if (o_cfg_ready !== ec) begin n_err++; $display("FAIL rnd_cfg_ready c=%0d: got %b, required %b", c, o_cfg_ready, ec); end
      if (o_ready !== er) begin n_err++; $display("FAIL rnd_ready c=%0d: got %b, required %b", c, o_ready, er); end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_swap_mask();
    test_backpressure();
    test_cfg_blocking();
    test_simul();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
